// File: rtl/mcu_pause_ctrl.sv
// rtl/mcu_pause_ctrl.sv - MCU boot/pause sequencer beside the Core
//
// Holds the Core in boot until the loader is done and BOOT_WAIT cycles have
// passed. Requests a Core pause from the Core's own PSE or from a debug pin,
// waits for the Core's acknowledge, and releases it on a debug resume pin.
//
// Ports:
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_loadDone             loader finished (synchronous level)
//   i_coreDoPause          Core PSE pause request
//   i_coreNowPsd           Core pause acknowledge
//   i_extPause/i_extResume asynchronous debug pins, rising edge is the event
//   o_isBooted             Core boot release
//   o_startPause           Core pause request
//   o_isPaused             Core fully paused
//   o_pauseErr             sticky acknowledge timeout
//   o_state                debug state: 0=BOOT 1=RUN 2=PAUSING 3=PAUSED

module mcu_pause_ctrl #(
  parameter int BOOT_WAIT     = 16,
  parameter int PAUSE_TIMEOUT = 8,
  parameter int CNT_W         = 8
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_loadDone,
  input  logic       i_coreDoPause,
  input  logic       i_coreNowPsd,
  input  logic       i_extPause,
  input  logic       i_extResume,
  output logic       o_isBooted,
  output logic       o_startPause,
  output logic       o_isPaused,
  output logic       o_pauseErr,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSING = 2'd2,
    ST_PAUSED  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] BW  = CNT_W'(BOOT_WAIT);
  localparam logic [CNT_W-1:0] PT  = CNT_W'(PAUSE_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             guard_q, guard_d;
  logic             err_q, err_d;
  logic             booted_q, booted_d;
  logic             start_q, start_d;
  logic             paused_q, paused_d;

  // [0],[1] synchronizer stages, [2] previous synchronized value.
  logic [2:0]       psync_q, psync_d;
  logic [2:0]       rsync_q, rsync_d;
  // Registered edge pulses: one cycle wide, three cycles after the pin rises.
  logic             pedge_q, pedge_d;
  logic             redge_q, redge_d;

  always_comb begin
    psync_d = {psync_q[1:0], i_extPause};
    rsync_d = {rsync_q[1:0], i_extResume};
    pedge_d = psync_q[1] & ~psync_q[2];
    redge_d = rsync_q[1] & ~rsync_q[2];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    guard_d = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_BOOT: begin
        // Ext edges are dropped here: nothing may be pending once booted.
        if ((cnt_q == BW) && i_loadDone) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q != BW) begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_RUN: begin
        if (pedge_q) begin
          pend_d = 1'b1;
        end
        // guard_q masks a PSE still draining through the pipe right after resume.
        if ((i_coreDoPause && !guard_q) || pend_q || pedge_q) begin
          state_d = ST_PAUSING;
          cnt_d   = '0;
        end
      end
      ST_PAUSING: begin
        if (i_coreNowPsd) begin
          state_d = ST_PAUSED;
          pend_d  = 1'b0;
        end else begin
          if (cnt_q != PT) begin
            cnt_d = cnt_q + ONE;
          end
          if (cnt_d == PT) begin
            err_d = 1'b1;
          end
        end
      end
      ST_PAUSED: begin
        // A simultaneous pause edge is simply not looked at: resume wins.
        if (redge_q) begin
          state_d = ST_RUN;
          guard_d = 1'b1;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with o_state.
  always_comb begin
    booted_d = (state_d != ST_BOOT);
    start_d  = (state_d == ST_PAUSING) || (state_d == ST_PAUSED);
    paused_d = (state_d == ST_PAUSED);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= ST_BOOT;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      guard_q  <= 1'b0;
      err_q    <= 1'b0;
      booted_q <= 1'b0;
      start_q  <= 1'b0;
      paused_q <= 1'b0;
      psync_q  <= '0;
      rsync_q  <= '0;
      pedge_q  <= 1'b0;
      redge_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      guard_q  <= guard_d;
      err_q    <= err_d;
      booted_q <= booted_d;
      start_q  <= start_d;
      paused_q <= paused_d;
      psync_q  <= psync_d;
      rsync_q  <= rsync_d;
      pedge_q  <= pedge_d;
      redge_q  <= redge_d;
    end
  end

  assign o_isBooted   = booted_q;
  assign o_startPause = start_q;
  assign o_isPaused   = paused_q;
  assign o_pauseErr   = err_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_mcu_pause_ctrl.sv
// tb/tb_mcu_pause_ctrl.sv - scoreboard bench for mcu_pause_ctrl

module tb_mcu_pause_ctrl;

  localparam int BW = 16;
  localparam int PT = 8;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_loadDone = 1'b0;
  logic       i_coreDoPause = 1'b0;
  logic       i_coreNowPsd = 1'b0;
  logic       i_extPause = 1'b0;
  logic       i_extResume = 1'b0;
  logic       o_isBooted;
  logic       o_startPause;
  logic       o_isPaused;
  logic       o_pauseErr;
  logic [1:0] o_state;

  mcu_pause_ctrl #(.BOOT_WAIT(BW), .PAUSE_TIMEOUT(PT), .CNT_W(8)) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_loadDone   (i_loadDone),
    .i_coreDoPause(i_coreDoPause),
    .i_coreNowPsd (i_coreNowPsd),
    .i_extPause   (i_extPause),
    .i_extResume  (i_extResume),
    .o_isBooted   (o_isBooted),
    .o_startPause (o_startPause),
    .o_isPaused   (o_isPaused),
    .o_pauseErr   (o_pauseErr),
    .o_state      (o_state)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit model_on = 1'b0;
  logic [5:0] sb[$];

  // Reference model: mode 0 boot, 1 run, 2 pausing, 3 paused.
  int  m_mode, m_age, m_nack;
  bit  m_pend, m_guard, m_err;
  bit [3:0] ph, rh;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [5:0] exp_vec();
    return {m_mode != 0, m_mode >= 2, m_mode == 3, m_err, 2'(m_mode)};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {o_isBooted, o_startPause, o_isPaused, o_pauseErr, o_state};
  endfunction

  // Advance the model one cycle using the inputs held during that cycle.
  task automatic model_step();
    bit pe, re, g;
    pe = ph[2] & ~ph[3];
    re = rh[2] & ~rh[3];
    g = m_guard;
    m_guard = 1'b0;
    case (m_mode)
      0: if (m_age >= BW && i_loadDone) m_mode = 1;
      1: begin
        if (pe) m_pend = 1'b1;
        if ((i_coreDoPause && !g) || m_pend) begin
          m_mode = 2;
          m_nack = 0;
        end
      end
      2: begin
        if (i_coreNowPsd) begin
          m_mode = 3;
          m_pend = 1'b0;
        end else begin
          m_nack++;
          if (m_nack >= PT) m_err = 1'b1;
        end
      end
      default: if (re) begin
        m_mode = 1;
        m_guard = 1'b1;
        m_pend = 1'b0;
      end
    endcase
    m_age++;
    ph = {ph[2:0], i_extPause};
    rh = {rh[2:0], i_extResume};
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (model_on) begin
      model_step();
      sb.push_back(exp_vec());
      cyc++;
    end
  endtask

  task automatic clear_inputs();
    i_loadDone = 1'b0;
    i_coreDoPause = 1'b0;
    i_coreNowPsd = 1'b0;
    i_extPause = 1'b0;
    i_extResume = 1'b0;
  endtask

  // Called just after a posedge; this cycle becomes cycle 0.
  task automatic release_reset();
    i_rstn = 1'b1;
    m_mode = 0; m_age = 0; m_nack = 0;
    m_pend = 1'b0; m_guard = 1'b0; m_err = 1'b0;
    ph = '0; rh = '0;
    cyc = 0;
    sb.delete();
    sb.push_back(exp_vec());
    model_on = 1'b1;
  endtask

  // Mid-cycle asynchronous reset; outputs must clear without a clock edge.
  task automatic async_reset(input string name);
    #2;
    i_rstn = 1'b0;
    model_on = 1'b0;
    sb.delete();
    #1;
    check(name, {2'b0, dut_vec()}, 8'h00);
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic run_boot(input int load_at, input int ext_at, input int exp_rise, input string name);
    int rise;
    rise = -1;
    release_reset();
    clear_inputs();
    for (int k = 0; k < exp_rise + 8; k++) begin
      tick();
      if (o_isBooted && rise < 0) rise = cyc;
      i_loadDone = (cyc >= load_at);
      i_extPause = (cyc == ext_at);
      i_extResume = (cyc == ext_at + 1);
    end
    check(name, 8'(rise), 8'(exp_rise));
    check({name, "_state"}, {6'b0, o_state}, 8'd1);
  endtask

  task automatic pulse_resume_to_run();
    i_extResume = 1'b1;
    tick();
    i_extResume = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pse_pause_and_ack();
    i_coreDoPause = 1'b1;
    tick();
    i_coreDoPause = 1'b0;
    i_coreNowPsd = 1'b1;
    tick();
    i_coreNowPsd = 1'b0;
    tick();
  endtask

  // Monitor: compares every registered output cycle against the scoreboard.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge i_clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("scoreboard", {2'b0, dut_vec()}, {2'b0, e});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    tick();
    tick();
    check("reset_outputs", {2'b0, dut_vec()}, 8'h00);

    run_boot(3, -10, 17, "boot_early_load");

    // PSE pause: request at N, ack at N+2.
    i_coreDoPause = 1'b1;
    tick();
    i_coreDoPause = 1'b0;
    check("pse_start_n1", {7'b0, o_startPause}, 8'd1);
    tick();
    i_coreNowPsd = 1'b1;
    tick();
    i_coreNowPsd = 1'b0;
    check("pse_paused_n3", {7'b0, o_isPaused}, 8'd1);
    // Resume pin at M, first RUN cycle at M+4 with PSE still asserted.
    i_extResume = 1'b1;
    tick();
    i_extResume = 1'b0;
    repeat (3) tick();
    check("resume_run", {6'b0, o_state}, 8'd1);
    check("resume_start_low", {6'b0, o_startPause, o_isPaused}, 8'd0);
    i_coreDoPause = 1'b1;
    tick();
    i_coreDoPause = 1'b0;
    tick();
    check("guard_stays_run", {6'b0, o_state}, 8'd1);

    // Ext pause pin: o_startPause four cycles after the pin rises.
    i_extPause = 1'b1;
    tick();
    i_extPause = 1'b0;
    tick();
    tick();
    check("ext_start_n3", {7'b0, o_startPause}, 8'd0);
    tick();
    check("ext_start_n4", {7'b0, o_startPause}, 8'd1);
    i_coreNowPsd = 1'b1;
    tick();
    i_coreNowPsd = 1'b0;
    check("ext_paused_state", {6'b0, o_state}, 8'd3);
    pulse_resume_to_run();
    tick();

    // Timeout: no ack while pausing.
    i_coreDoPause = 1'b1;
    tick();
    i_coreDoPause = 1'b0;
    repeat (7) tick();
    check("timeout_not_yet", {7'b0, o_pauseErr}, 8'd0);
    repeat (3) tick();
    check("timeout_err", {7'b0, o_pauseErr}, 8'd1);
    i_coreNowPsd = 1'b1;
    tick();
    i_coreNowPsd = 1'b0;
    pulse_resume_to_run();
    tick();
    check("err_sticky", {6'b0, o_pauseErr, o_state[0]}, 8'd3);

    // Pause and resume edges together in PAUSED.
    pse_pause_and_ack();
    check("coll_paused", {6'b0, o_state}, 8'd3);
    i_extPause = 1'b1;
    i_extResume = 1'b1;
    tick();
    i_extPause = 1'b0;
    i_extResume = 1'b0;
    repeat (10) tick();
    check("coll_run", {6'b0, o_state}, 8'd1);

    // Asynchronous reset while paused, with the sticky error set.
    pse_pause_and_ack();
    check("pre_reset_paused", {6'b0, o_state}, 8'd3);
    async_reset("async_reset_paused");

    run_boot(40, 5, 41, "boot_late_load");

    // Randomized traffic with occasional mid-cycle resets.
    for (int k = 0; k < 3000; k++) begin
      tick();
      i_loadDone    = ($urandom_range(0, 99) < 50);
      i_coreDoPause = ($urandom_range(0, 99) < 8);
      i_coreNowPsd  = ($urandom_range(0, 99) < 20);
      i_extPause    = ($urandom_range(0, 99) < 6);
      i_extResume   = ($urandom_range(0, 99) < 10);
      if (k % 700 == 699) begin
        async_reset("async_reset_random");
        release_reset();
      end
    end

    tick();
    @(negedge i_clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
